// File: rtl/timer_bus_bridge_if.sv
// CPU-side single-word load/store bus between the CPU data port and
// the timer bus bridge. The CPU holds a request until it sees the
// one-cycle acknowledge.
interface timer_bus_bridge_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;

    // CPU side: issues requests, receives data and completion.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err
    );

    // Bridge side: accepts requests, returns data and completion.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err
    );
endinterface

// File: rtl/timer_bus_bridge.sv
// Bus initiator for the timer peripherals. Decodes CPU accesses onto
// two timer register windows and a local interrupt block (PEND/MASK),
// returns read data with a one-cycle acknowledge, and folds the timer
// level interrupts into edge-detected, maskable pending bits.
module timer_bus_bridge #(
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10,
    parameter logic [31:0] BRIDGE_BASE = 32'h0000_7F20
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    timer_bus_bridge_if.slave     cpu,
    output logic [1:0]            DEV_ADDR_O,
    output logic [31:0]           DEV_DAT_O,
    output logic                  DEV_WE0_O,
    output logic                  DEV_WE1_O,
    input  logic [31:0]           DEV0_DAT_I,
    input  logic [31:0]           DEV1_DAT_I,
    input  logic                  IRQ0_I,
    input  logic                  IRQ1_I,
    output logic                  HWINT_O
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Target of the current access; SEL_NONE marks an unmapped address.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_T0,
        SEL_T1,
        SEL_PEND,
        SEL_MASK
    } sel_t;

    state_t      state_q, state_d;
    sel_t        dec_sel;
    sel_t        sel_q;
    logic [1:0]  off_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;

    logic [1:0]  irq_now;
    logic [1:0]  irq_d;
    logic [1:0]  pend_q;
    logic [1:0]  mask_q;
    logic [1:0]  pend_set;
    logic [1:0]  pend_clr;
    logic        hwint_q;
    logic        bridge_wr;

    // Byte-lane bits of the address carry no meaning for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu.cpu_addr[1:0];

    // Address decode of the incoming request into a target select.
    always_comb begin
        dec_sel = SEL_NONE;
        if (cpu.cpu_addr[31:4] == TIMER0_BASE[31:4]) begin
            if (cpu.cpu_addr[3:2] != 2'd3) dec_sel = SEL_T0;
        end else if (cpu.cpu_addr[31:4] == TIMER1_BASE[31:4]) begin
            if (cpu.cpu_addr[3:2] != 2'd3) dec_sel = SEL_T1;
        end else if (cpu.cpu_addr[31:4] == BRIDGE_BASE[31:4]) begin
            case (cpu.cpu_addr[3:2])
                2'd0:    dec_sel = SEL_PEND;
                2'd1:    dec_sel = SEL_MASK;
                default: dec_sel = SEL_NONE;
            endcase
        end
    end

    // FSM state register; reset aborts any transaction in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and per-state outputs (strobes, ack, error, data).
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        DEV_WE0_O     = 1'b0;
        DEV_WE1_O     = 1'b0;
        cpu.cpu_ack   = 1'b0;
        cpu.cpu_err   = 1'b0;
        cpu.cpu_rdata = 32'h0;
        case (state_q)
            IDLE: begin
                if (cpu.cpu_req) state_d = ACCESS;
            end
            ACCESS: begin
                DEV_WE0_O = we_q && (sel_q == SEL_T0);
                DEV_WE1_O = we_q && (sel_q == SEL_T1);
                state_d   = RESP;
            end
            RESP: begin
                cpu.cpu_ack   = 1'b1;
                cpu.cpu_err   = (sel_q == SEL_NONE);
                cpu.cpu_rdata = rdata_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register the request fields and decode result when it is accepted.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sel_q   <= SEL_NONE;
            off_q   <= 2'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
        end else if (state_q == IDLE && cpu.cpu_req) begin
            sel_q   <= dec_sel;
            off_q   <= cpu.cpu_addr[3:2];
            we_q    <= cpu.cpu_we;
            wdata_q <= cpu.cpu_wdata;
        end
    end

    assign DEV_ADDR_O = off_q;
    assign DEV_DAT_O  = wdata_q;

    // Read data source for the registered target.
    always_comb begin
        rd_mux = 32'h0;
        case (sel_q)
            SEL_T0:   rd_mux = DEV0_DAT_I;
            SEL_T1:   rd_mux = DEV1_DAT_I;
            SEL_PEND: rd_mux = {30'h0, pend_q};
            SEL_MASK: rd_mux = {30'h0, mask_q};
            default:  rd_mux = 32'h0;
        endcase
    end

    // Capture read data at the end of ACCESS; writes return zero.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)                 rdata_q <= 32'h0;
        else if (state_q == ACCESS) rdata_q <= we_q ? 32'h0 : rd_mux;
    end

    assign irq_now   = {IRQ1_I, IRQ0_I};
    assign bridge_wr = (state_q == ACCESS) && we_q;
    assign pend_set  = irq_now & ~irq_d;
    assign pend_clr  = (bridge_wr && sel_q == SEL_PEND) ? wdata_q[1:0] : 2'b00;

    // Interrupt edge detect, pending (set beats clear), mask, and output.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            irq_d   <= 2'b00;
            pend_q  <= 2'b00;
            mask_q  <= 2'b00;
            hwint_q <= 1'b0;
        end else begin
            irq_d   <= irq_now;
            pend_q  <= (pend_q & ~pend_clr) | pend_set;
            if (bridge_wr && sel_q == SEL_MASK) mask_q <= wdata_q[1:0];
            hwint_q <= |(pend_q & mask_q);
        end
    end

    assign HWINT_O = hwint_q;

endmodule

// File: tb/tb_timer_bus_bridge.sv
// Self-checking bench for timer_bus_bridge: bus transactions push their
// expected response to a scoreboard queue, and a monitor pops and
// compares it whenever the bridge acknowledges.
module tb_timer_bus_bridge;

    logic        CLK_I;
    logic        RST_I;
    logic [1:0]  DEV_ADDR_O;
    logic [31:0] DEV_DAT_O;
    logic        DEV_WE0_O;
    logic        DEV_WE1_O;
    logic [31:0] DEV0_DAT_I;
    logic [31:0] DEV1_DAT_I;
    logic        IRQ0_I;
    logic        IRQ1_I;
    logic        HWINT_O;

    timer_bus_bridge_if bus ();

    timer_bus_bridge dut (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .cpu        (bus),
        .DEV_ADDR_O (DEV_ADDR_O),
        .DEV_DAT_O  (DEV_DAT_O),
        .DEV_WE0_O  (DEV_WE0_O),
        .DEV_WE1_O  (DEV_WE1_O),
        .DEV0_DAT_I (DEV0_DAT_I),
        .DEV1_DAT_I (DEV1_DAT_I),
        .IRQ0_I     (IRQ0_I),
        .IRQ1_I     (IRQ1_I),
        .HWINT_O    (HWINT_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int errors = 0;

    // Expected {err, rdata} per transaction, in issue order.
    logic [32:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every acknowledge must match the oldest expectation.
    always @(negedge CLK_I) begin
        if (bus.cpu_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("rdata", bus.cpu_rdata, e[31:0]);
                check("err", {31'h0, bus.cpu_err}, {31'h0, e[32]});
            end
        end
    end

    // One CPU access; called and returning on a falling edge.
    task automatic bus_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit exp_err,
                              input bit exp_we0, input bit exp_we1, input bit irq0_in_access);
        int n;
        sb_q.push_back({exp_err, exp_rdata});
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(posedge CLK_I);
        @(negedge CLK_I);
        check("access_we0", {31'h0, DEV_WE0_O}, {31'h0, exp_we0});
        check("access_we1", {31'h0, DEV_WE1_O}, {31'h0, exp_we1});
        check("dev_addr", {30'h0, DEV_ADDR_O}, {30'h0, addr[3:2]});
        if (we) check("dev_dat", DEV_DAT_O, wdata);
        check("ack_early", {31'h0, bus.cpu_ack}, 32'd0);
        if (irq0_in_access) IRQ0_I = 1'b1;
        n = 0;
        @(negedge CLK_I);
        while (bus.cpu_ack !== 1'b1 && n < 4) begin
            @(negedge CLK_I);
            n++;
        end
        check("ack_latency", n, 32'd0);
        check("resp_we0", {31'h0, DEV_WE0_O}, 32'd0);
        check("resp_we1", {31'h0, DEV_WE1_O}, 32'd0);
        bus.cpu_req = 1'b0;
        @(negedge CLK_I);
        check("ack_pulse", {31'h0, bus.cpu_ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        RST_I         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        DEV0_DAT_I    = 32'hCAFE_0001;
        DEV1_DAT_I    = 32'h0000_1234;
        IRQ0_I        = 1'b0;
        IRQ1_I        = 1'b0;
        #12;
        check("rst_ack", {31'h0, bus.cpu_ack}, 32'd0);
        check("rst_err", {31'h0, bus.cpu_err}, 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        check("rst_we0", {31'h0, DEV_WE0_O}, 32'd0);
        check("rst_we1", {31'h0, DEV_WE1_O}, 32'd0);
        check("rst_hwint", {31'h0, HWINT_O}, 32'd0);
        check("rst_dev_addr", {30'h0, DEV_ADDR_O}, 32'd0);
        check("rst_dev_dat", DEV_DAT_O, 32'd0);
        @(negedge CLK_I);
        RST_I = 1'b0;
        @(negedge CLK_I);

        // Timer writes and reads.
        bus_access(1'b1, 32'h0000_7F00, 32'h9,        32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
        bus_access(1'b0, 32'h0000_7F18, 32'h0,        32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_access(1'b0, 32'h0000_7F04, 32'h0,        32'hCAFE_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        bus_access(1'b1, 32'h0000_7F14, 32'h7,        32'h0,         1'b0, 1'b0, 1'b1, 1'b0);

        // Unmapped accesses.
        bus_access(1'b0, 32'h0000_7F0C, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
        bus_access(1'b1, 32'h0000_8000, 32'hFFFF_FFFF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
        bus_access(1'b0, 32'h0000_7F28, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0, 1'b0);
        bus_access(1'b1, 32'h0000_7F1C, 32'h5,        32'h0,         1'b1, 1'b0, 1'b0, 1'b0);

        // Mask register and interrupt path.
        bus_access(1'b1, 32'h0000_7F24, 32'h1,        32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
        bus_access(1'b0, 32'h0000_7F24, 32'h0,        32'h1,         1'b0, 1'b0, 1'b0, 1'b0);
        check("hwint_idle", {31'h0, HWINT_O}, 32'd0);
        IRQ0_I = 1'b1;
        @(negedge CLK_I);
        check("hwint_lag", {31'h0, HWINT_O}, 32'd0);
        @(negedge CLK_I);
        check("hwint_rise", {31'h0, HWINT_O}, 32'd1);
        bus_access(1'b0, 32'h0000_7F20, 32'h0,        32'h1,         1'b0, 1'b0, 1'b0, 1'b0);
        bus_access(1'b1, 32'h0000_7F20, 32'h1,        32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
        check("hwint_cleared", {31'h0, HWINT_O}, 32'd0);
        bus_access(1'b0, 32'h0000_7F20, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
        IRQ1_I = 1'b1;
        repeat (3) @(negedge CLK_I);
        check("hwint_masked", {31'h0, HWINT_O}, 32'd0);
        bus_access(1'b0, 32'h0000_7F20, 32'h0,        32'h2,         1'b0, 1'b0, 1'b0, 1'b0);

        // Clear and new rising edge on the same edge: set wins.
        IRQ0_I = 1'b0;
        repeat (2) @(negedge CLK_I);
        bus_access(1'b1, 32'h0000_7F20, 32'h1,        32'h0,         1'b0, 1'b0, 1'b0, 1'b1);
        check("hwint_set_wins", {31'h0, HWINT_O}, 32'd1);
        bus_access(1'b0, 32'h0000_7F20, 32'h0,        32'h3,         1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during ACCESS of a timer write aborts it.
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h0000_7F04;
        bus.cpu_wdata = 32'h5;
        @(posedge CLK_I);
        @(negedge CLK_I);
        check("abort_we0_pre", {31'h0, DEV_WE0_O}, 32'd1);
        #2 RST_I = 1'b1;
        #1;
        check("abort_we0_drop", {31'h0, DEV_WE0_O}, 32'd0);
        check("abort_ack", {31'h0, bus.cpu_ack}, 32'd0);
        check("abort_hwint", {31'h0, HWINT_O}, 32'd0);
        bus.cpu_req = 1'b0;
        @(negedge CLK_I);
        check("abort_no_ack", {31'h0, bus.cpu_ack}, 32'd0);
        RST_I = 1'b0;
        // Both IRQ lines are still high, so PEND sets on the first edge.
        bus_access(1'b0, 32'h0000_7F20, 32'h0,        32'h3,         1'b0, 1'b0, 1'b0, 1'b0);
        bus_access(1'b0, 32'h0000_7F24, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_hwint", {31'h0, HWINT_O}, 32'd0);

        repeat (3) @(negedge CLK_I);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_bus_bridge.md
# timer_bus_bridge

CPU-facing bus initiator for the timer peripherals: accepts single-word CPU load/store requests, decodes them onto two timer register windows plus a local interrupt block, drives the timers' `ADDR`/`WE`/`DAT` inputs, and returns read data with a one-cycle acknowledge. It also latches the timers' level `IRQ` outputs into edge-detected, maskable pending bits and presents a single interrupt line to the CPU. It sits between the CPU data port and the timer instances.

## Interface
- `TIMER0_BASE`, default 32'h0000_7F00: 16-byte window of timer 0.
- `TIMER1_BASE`, default 32'h0000_7F10: 16-byte window of timer 1.
- `BRIDGE_BASE`, default 32'h0000_7F20: 16-byte window of the local interrupt registers.
- `CLK_I`  in  1  clock; all state changes on the rising edge.
- `RST_I`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data, valid while `cpu_ack` = 1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  unmapped-access flag, valid with `cpu_ack`.
- `DEV_ADDR_O`  out  2  word offset to timers (their `ADDR_I[3:2]`).
- `DEV_DAT_O`  out  32  write data to timers.
- `DEV_WE0_O`, `DEV_WE1_O`  out  1 each  write strobe, timer 0 and timer 1.
- `DEV0_DAT_I`, `DEV1_DAT_I`  in  32 each  timer read data (combinational in the timer).
- `IRQ0_I`, `IRQ1_I`  in  1 each  timer level interrupts.
- `HWINT_O`  out  1  CPU interrupt request.

## Operation
- Decode on `cpu_addr[31:4]`. Word offset = `cpu_addr[3:2]`.
  - Timer window: offsets 0–2 are valid.
  - Timer window, offset 3: unmapped.
  - Bridge window, offset 0: `PEND` (bits [1:0]; read; write-1-to-clear).
  - Bridge window, offset 1: `MASK` (bits [1:0]; read/write).
  - Bridge window, offsets 2–3: unmapped.
  - Any address outside the three windows: unmapped.
  - Unused read bits return 0.
- FSM states: `IDLE`, `ACCESS`, `RESP`.
  - `IDLE`: when `cpu_req` = 1, register the address, `we`, `wdata` and the decode result, then go to `ACCESS`. Otherwise stay in `IDLE`.
  - `ACCESS`: drive `DEV_ADDR_O` and `DEV_DAT_O` from the registered values.
    - On a write to timer *i*, assert `DEV_WEi_O` for exactly this cycle.
    - On a read, capture the data source into the read register at the closing edge: selected `DEVi_DAT_I`, `PEND`, or `MASK`.
    - Bridge-register writes take effect at the closing edge.
    - Go to `RESP`.
  - `RESP`: assert `cpu_ack` = 1. `cpu_rdata` = captured data, or 0 for writes and unmapped accesses. `cpu_err` = 1 if unmapped. Go to `IDLE`.
  - `cpu_req` is ignored outside `IDLE`.
- Unmapped accesses: no `DEV_WE*` asserted, no state change, `cpu_err` = 1.
- Interrupts: `irq_d[i]` is the value of `IRQi_I` registered each cycle.
  - `PEND[i]` is set on a rising edge (`IRQi_I` & ~`irq_d[i]`).
  - A write-1 to `PEND[i]` clears it.
  - If a set and a clear occur in the same cycle, set wins.
  - A level that remains high after clearing does not re-set `PEND[i]`.
  - `HWINT_O` = |(`PEND` & `MASK`), registered.

## Timing
- Reset (asynchronous, immediate): FSM to `IDLE`; `cpu_ack`, `cpu_err`, `DEV_WE0_O`, `DEV_WE1_O`, `HWINT_O` = 0; `cpu_rdata`, `DEV_ADDR_O`, `DEV_DAT_O` = 0; `PEND`, `MASK`, `irq_d` = 0.
- Reset mid-transaction aborts it: no ack, any write strobe is dropped, and the CPU reissues the access.
- Because `irq_d` resets to 0, an IRQ that is already high after reset sets `PEND` on the first clocked edge.
- Latency: `cpu_req` sampled at edge *k*; `DEV_WE` is high during cycle *k*..*k*+1; `cpu_ack` is high during cycle *k*+1..*k*+2.
- The timer samples its write at edge *k*+1.
- Minimum request spacing: 3 cycles. A `cpu_req` still high in the cycle after `cpu_ack` starts a new transaction.
- Interrupt path: `IRQi_I` rising before edge *n* sets `PEND` at *n*; `HWINT_O` goes high at *n*+1 if the bit is masked on.

## Test plan
- Write 32'h9 to 0x7F00 → `DEV_WE0_O` = 1 for exactly one cycle with `DEV_ADDR_O` = 0, `DEV_DAT_O` = 9; `DEV_WE1_O` stays 0; `cpu_ack` 2 cycles after the request; `cpu_err` = 0.
- Timer 1 count = 32'h1234; read 0x7F18 → `cpu_rdata` = 32'h1234 with `cpu_ack`; no write strobe.
- Read 0x7F0C, then write 0x8000 → each gives `cpu_ack` = 1, `cpu_err` = 1, `cpu_rdata` = 0, no `DEV_WE*`.
- `MASK` = 2'b01; raise `IRQ0_I` and hold it → `PEND` = 01, then `HWINT_O` = 1; write 1 to 0x7F20 → `PEND` = 0 and `HWINT_O` falls while `IRQ0_I` stays high; raising `IRQ1_I` sets `PEND[1]` but `HWINT_O` stays 0.
- W1C of `PEND[0]` in the same cycle as a new `IRQ0_I` rising edge → `PEND[0]` remains 1.
- Assert `RST_I` during `ACCESS` of a write → `DEV_WE0_O` drops immediately, no `cpu_ack`; after release, a fresh read completes normally.
